// File: rtl/sdram_fifo_pkg.sv
// Shared definitions for the SDRAM controller FIFOs (single- and dual-clock).
package sdram_fifo_pkg;

    // Read-mode encodings for the FWFT parameter.
    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Pointer width: one extra bit above the address so full and empty differ.
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH register array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store the write word on the rising edge.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through read, almost
// thresholds, synchronous flush, sticky error flags and an occupancy count.
module sync_fifo
    import sdram_fifo_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clr,
    input  logic                   i_wr_en,
    input  logic [WIDTH-1:0]       i_wr_data,
    output logic                   o_wr_full,
    output logic                   o_almost_full,
    input  logic                   i_rd_en,
    output logic [WIDTH-1:0]       o_rd_data,
    output logic                   o_rd_valid,
    output logic                   o_rd_empty,
    output logic                   o_almost_empty,
    output logic [$clog2(DEPTH):0] o_use,
    output logic                   o_overflow,
    output logic                   o_underflow
);

    localparam int PW = fifo_ptr_w(DEPTH);
    localparam int AW = PW - 1;

    localparam logic [PW-1:0] USE_FULL = PW'(DEPTH);
    localparam logic [PW-1:0] USE_AF   = PW'(AF_LEVEL);
    localparam logic [PW-1:0] USE_AE   = PW'(AE_LEVEL);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] mem_rd_data;

    // Flags come straight from the registered occupancy.
    assign o_wr_full      = (o_use == USE_FULL);
    assign o_rd_empty     = (o_use == '0);
    assign o_almost_full  = (o_use >= USE_AF);
    assign o_almost_empty = (o_use <= USE_AE);

    // Acceptance looks only at registered state; a same-cycle pop never frees
    // room for a write and a same-cycle push never feeds a read.
    assign wr_acc = i_wr_en && !o_wr_full;
    assign rd_acc = i_rd_en && !o_rd_empty;

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_use       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else if (i_clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_use       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_acc && !rd_acc) begin
                o_use <= o_use + PTR_ONE;
            end else if (rd_acc && !wr_acc) begin
                o_use <= o_use - PTR_ONE;
            end
            if (i_wr_en && o_wr_full) begin
                o_overflow <= 1'b1;
            end
            if (i_rd_en && o_rd_empty) begin
                o_underflow <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk     (i_clk),
        .i_wr_en   (wr_acc && !i_clr),
        .i_wr_addr (wr_ptr[AW-1:0]),
        .i_wr_data (i_wr_data),
        .i_rd_addr (rd_ptr[AW-1:0]),
        .o_rd_data (mem_rd_data)
    );

    if (FWFT == FIFO_FWFT) begin : g_fwft
        // Head word is presented directly; masked to zero while empty.
        assign o_rd_data  = o_rd_empty ? '0 : mem_rd_data;
        assign o_rd_valid = !o_rd_empty;
    end else begin : g_std
        // Register the head word one cycle after an accepted read.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                o_rd_data  <= '0;
                o_rd_valid <= 1'b0;
            end else if (i_clr) begin
                o_rd_data  <= '0;
                o_rd_valid <= 1'b0;
            end else begin
                o_rd_valid <= rd_acc;
                if (rd_acc) begin
                    o_rd_data <= mem_rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a standard-read and an FWFT instance share one stimulus
// stream and are compared every cycle against a queue-based model.
module tb_sync_fifo;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int UW = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [W-1:0] wr_data = '0;

    logic [W-1:0]  s_rd_data, f_rd_data;
    logic [UW-1:0] s_use, f_use;
    logic s_full, s_af, s_valid, s_empty, s_ae, s_ovf, s_unf;
    logic f_full, f_af, f_valid, f_empty, f_ae, f_ovf, f_unf;

    always #5 clk = ~clk;

    sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) u_std (
        .i_clk(clk), .i_rst(rst), .i_clr(clr),
        .i_wr_en(wr_en), .i_wr_data(wr_data),
        .o_wr_full(s_full), .o_almost_full(s_af),
        .i_rd_en(rd_en), .o_rd_data(s_rd_data), .o_rd_valid(s_valid),
        .o_rd_empty(s_empty), .o_almost_empty(s_ae), .o_use(s_use),
        .o_overflow(s_ovf), .o_underflow(s_unf)
    );

    sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)) u_fwft (
        .i_clk(clk), .i_rst(rst), .i_clr(clr),
        .i_wr_en(wr_en), .i_wr_data(wr_data),
        .o_wr_full(f_full), .o_almost_full(f_af),
        .i_rd_en(rd_en), .o_rd_data(f_rd_data), .o_rd_valid(f_valid),
        .o_rd_empty(f_empty), .o_almost_empty(f_ae), .o_use(f_use),
        .o_overflow(f_ovf), .o_underflow(f_unf)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of words plus the flags the rules define.
    logic [W-1:0] mq[$];
    bit           m_ovf = 1'b0;
    bit           m_unf = 1'b0;
    bit           m_sv  = 1'b0;
    logic [W-1:0] m_sd  = '0;
    bit           m_full, m_empty;

    always @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_sv  = 1'b0;
            m_sd  = '0;
        end else begin
            m_full  = (mq.size() == D);
            m_empty = (mq.size() == 0);
            if (wr_en && m_full)  m_ovf = 1'b1;
            if (rd_en && m_empty) m_unf = 1'b1;
            if (rd_en && !m_empty) begin
                m_sd = mq.pop_front();
                m_sv = 1'b1;
            end else begin
                m_sv = 1'b0;
            end
            if (wr_en && !m_full) mq.push_back(wr_data);
        end
    end

    int           c_n;
    logic [W-1:0] c_head;

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            c_n    = mq.size();
            c_head = (c_n != 0) ? mq[0] : '0;
            check("use_std",   32'(s_use),   c_n);
            check("use_fwft",  32'(f_use),   c_n);
            check("full_std",  32'(s_full),  32'(c_n == D));
            check("full_fwft", 32'(f_full),  32'(c_n == D));
            check("empty_std", 32'(s_empty), 32'(c_n == 0));
            check("empty_fwft",32'(f_empty), 32'(c_n == 0));
            check("af_std",    32'(s_af),    32'(c_n >= 14));
            check("ae_std",    32'(s_ae),    32'(c_n <= 2));
            check("af_fwft",   32'(f_af),    32'(c_n >= 14));
            check("ae_fwft",   32'(f_ae),    32'(c_n <= 2));
            check("ovf_std",   32'(s_ovf),   32'(m_ovf));
            check("unf_std",   32'(s_unf),   32'(m_unf));
            check("ovf_fwft",  32'(f_ovf),   32'(m_ovf));
            check("unf_fwft",  32'(f_unf),   32'(m_unf));
            check("data_std",  32'(s_rd_data), 32'(m_sd));
            check("valid_std", 32'(s_valid),   32'(m_sv));
            check("data_fwft", 32'(f_rd_data), 32'(c_head));
            check("valid_fwft",32'(f_valid),   32'(c_n != 0));
        end
    end

    // Drive one cycle of inputs, then return just after the following falling edge.
    task automatic step(input bit w, input logic [W-1:0] d, input bit r, input bit c);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr     = c;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pw, pr;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        cmp_en = 1'b1;

        check("rst_use",    32'(s_use), 0);
        check("rst_empty",  32'(s_empty), 1);
        check("rst_full",   32'(s_full), 0);
        check("rst_ae",     32'(s_ae), 1);
        check("rst_af",     32'(s_af), 0);
        check("rst_valid",  32'(s_valid), 0);
        check("rst_data",   32'(s_rd_data), 0);
        check("rst_fvalid", 32'(f_valid), 0);
        check("rst_fdata",  32'(f_rd_data), 0);

        // Fill with 0x0001..0x0010.
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, W'(k), 1'b0, 1'b0);
            if (k == 13) check("af_at_13", 32'(s_af), 0);
            if (k == 14) check("af_at_14", 32'(s_af), 1);
        end
        check("fill_full", 32'(s_full), 1);
        check("fill_use",  32'(s_use), 16);
        check("fill_fhead", 32'(f_rd_data), 32'h0001);
        step(1'b1, 16'h0011, 1'b0, 1'b0);
        check("ovf_use",  32'(s_use), 16);
        check("ovf_flag", 32'(s_ovf), 1);

        // Drain with read held.
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check("drain_data",  32'(s_rd_data), k);
            check("drain_valid", 32'(s_valid), 1);
        end
        check("drain_empty", 32'(s_empty), 1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("unf_flag",  32'(s_unf), 1);
        check("unf_valid", 32'(s_valid), 0);
        check("unf_hold",  32'(s_rd_data), 32'h0010);

        step(1'b0, '0, 1'b0, 1'b1);
        check("clr_ovf", 32'(s_ovf), 0);
        check("clr_unf", 32'(s_unf), 0);
        check("clr_data", 32'(s_rd_data), 0);

        // FWFT fall-through and pop.
        step(1'b1, 16'hABCD, 1'b0, 1'b0);
        check("fwft_valid", 32'(f_valid), 1);
        check("fwft_data",  32'(f_rd_data), 32'hABCD);
        step(1'b0, '0, 1'b1, 1'b0);
        check("fwft_pop_valid", 32'(f_valid), 0);
        check("fwft_pop_data",  32'(f_rd_data), 0);
        check("std_pop_data",   32'(s_rd_data), 32'hABCD);
        step(1'b0, '0, 1'b0, 1'b0);

        // Steady streaming at occupancy 8 across pointer wraps.
        for (int i = 0; i < 8; i++) step(1'b1, W'(100 + i), 1'b0, 1'b0);
        check("stream_fill", 32'(s_use), 8);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, W'(108 + i), 1'b1, 1'b0);
            check("stream_use",  32'(s_use), 8);
            check("stream_data", 32'(s_rd_data), 100 + i);
            check("stream_head", 32'(f_rd_data), 101 + i);
        end

        // Full with simultaneous read and write.
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, W'(16'h0200 + i), 1'b0, 1'b0);
        step(1'b1, 16'h02FF, 1'b1, 1'b0);
        check("fullrw_use",  32'(s_use), 15);
        check("fullrw_ovf",  32'(s_ovf), 1);
        check("fullrw_data", 32'(s_rd_data), 32'h0200);
        check("fullrw_head", 32'(f_rd_data), 32'h0201);

        // Empty with simultaneous read and write.
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 16'h0055, 1'b1, 1'b0);
        check("emptyrw_use",   32'(s_use), 1);
        check("emptyrw_unf",   32'(s_unf), 1);
        check("emptyrw_valid", 32'(s_valid), 0);
        check("emptyrw_head",  32'(f_rd_data), 32'h0055);

        // Flush with five entries and both flags set.
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, W'(16'h0300 + i), 1'b0, 1'b0);
        step(1'b1, '0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("pre_clr_use", 32'(s_use), 5);
        check("pre_clr_ovf", 32'(s_ovf), 1);
        check("pre_clr_unf", 32'(s_unf), 1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("flush_use",   32'(s_use), 0);
        check("flush_empty", 32'(s_empty), 1);
        check("flush_ovf",   32'(s_ovf), 0);
        check("flush_unf",   32'(s_unf), 0);
        check("flush_fvalid", 32'(f_valid), 0);

        // Asynchronous reset in the middle of a burst, between clock edges.
        for (int i = 0; i < 6; i++) step(1'b1, W'(16'h0400 + i), i > 2, 1'b0);
        wr_en = 1'b1;
        rd_en = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check("arst_use",   32'(s_use), 0);
        check("arst_fuse",  32'(f_use), 0);
        check("arst_empty", 32'(s_empty), 1);
        check("arst_valid", 32'(s_valid), 0);
        check("arst_data",  32'(s_rd_data), 0);
        check("arst_fdata", 32'(f_rd_data), 0);
        check("arst_ovf",   32'(s_ovf), 0);
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Randomised traffic in windows with varying write/read pressure.
        for (int blk = 0; blk < 8; blk++) begin
            pw = int'($urandom_range(20, 90));
            pr = int'($urandom_range(20, 90));
            for (int n = 0; n < 250; n++) begin
                step(int'($urandom_range(0, 99)) < pw, W'($urandom),
                     int'($urandom_range(0, 99)) < pr, $urandom_range(0, 199) == 0);
            end
        end
        step(1'b0, '0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
